// File: rtl/rshift.sv
// Registered barrel right-shifter: out <= value_in >> distance (logical; arithmetic with RSHIFT_ARITH_EN).
// Latency: 1 cycle. Result is captured on every rising clock edge.
// No backpressure: there is no enable or handshake, and out updates on every edge.
module rshift #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic [WIDTH-1:0] distance,
   input  logic [WIDTH-1:0] value_in,
   output logic [WIDTH-1:0] out,
   input  logic             reset
`ifdef RSHIFT_ARITH_EN
   ,
   input  logic             arith
`endif
);

   // The in-range stages shift by 1, 2, 4, and so on.
   // Together they cover every shift distance below 2**STAGES.
   // Any higher distance bit means the operand is shifted completely out.
   localparam int STAGES = $clog2(WIDTH);

   logic             fill;
   logic             ovf;
   logic [WIDTH-1:0] stage [0:STAGES];
   logic [WIDTH-1:0] result;

   // Choose the value for the vacated MSBs.
   // The sign bit is used only when an arithmetic shift is requested.
`ifdef RSHIFT_ARITH_EN
   assign fill = arith & value_in[WIDTH-1];
`else
   assign fill = 1'b0;
`endif

   assign stage[0] = value_in;

   // Each barrel stage shifts by a fixed power of two.
   // A stage shifts only when its distance bit is set.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int SH = 1 << k;
      assign stage[k+1] = distance[k] ? {{SH{fill}}, stage[k][WIDTH-1:SH]} : stage[k];
   end

   // Detect a distance of 2**STAGES or more.
   // Such a distance is always >= WIDTH, so it never wraps.
   if (STAGES < WIDTH) begin : g_ovf
      assign ovf = |distance[WIDTH-1:STAGES];
   end else begin : g_no_ovf
      assign ovf = 1'b0;
   end

   // An out-of-range distance saturates the result to all fill bits.
   assign result = ovf ? {WIDTH{fill}} : stage[STAGES];

   // Register the shifted result. Reset clears it without needing a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out <= '0;
      end else begin
         out <= result;
      end
   end

endmodule

// File: tb/tb_rshift.sv
// Directed self-checking bench for rshift with WIDTH=4.
// Inputs are driven on the falling edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_rshift;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] distance;
   logic [3:0] value_in;
   logic [3:0] out;
`ifdef RSHIFT_ARITH_EN
   logic       arith;
`endif

   int checks = 0;
   int failures = 0;

   rshift #(.WIDTH(4)) dut (
      .clock    (clock),
      .distance (distance),
      .value_in (value_in),
      .out      (out),
      .reset    (reset)
`ifdef RSHIFT_ARITH_EN
      ,
      .arith    (arith)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Apply one input vector, clock it in, then check the registered result.
   task automatic step(input string tag, input logic [3:0] d, input logic [3:0] v, input logic [3:0] exp);
      @(negedge clock);
      distance = d;
      value_in = v;
      @(posedge clock);
      #1;
      check(tag, out, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      distance = 4'd0;
      value_in = 4'b0000;
`ifdef RSHIFT_ARITH_EN
      arith    = 1'b0;
`endif
      #1;
      check("reset_initial", out, 4'b0000);
      @(negedge clock);
      reset = 1'b0;

      // Main function with distance=2 over a sequence of operands.
      step("d2_0010", 4'd2, 4'b0010, 4'b0000);
      step("d2_0100", 4'd2, 4'b0100, 4'b0001);
      step("d2_0110", 4'd2, 4'b0110, 4'b0001);
      step("d2_1010", 4'd2, 4'b1010, 4'b0010);

      // Pass-through at distance 0, and a shift by 3.
      step("d0_pass", 4'd0, 4'b1011, 4'b1011);
      step("d3_1000", 4'd3, 4'b1000, 4'b0001);
      step("d1_1111", 4'd1, 4'b1111, 4'b0111);

      // Out-of-range distances must not wrap.
      step("d4_oor",  4'd4,  4'b1111, 4'b0000);
      step("d15_oor", 4'd15, 4'b1111, 4'b0000);
      step("d6_oor",  4'd6,  4'b1111, 4'b0000);

      // Apply an asynchronous reset in the middle of the cycle.
      step("pre_reset", 4'd1, 4'b0100, 4'b0010);
      #2;
      reset = 1'b1;
      #1;
      check("reset_async", out, 4'b0000);
      @(posedge clock);
      #1;
      check("reset_held_edge", out, 4'b0000);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("reset_released_no_edge", out, 4'b0000);
      @(posedge clock);
      #1;
      check("first_capture", out, 4'b0010);

      // Inputs that change between edges must not reach out before the next edge.
      step("lat_base", 4'd1, 4'b0000, 4'b0000);
      @(negedge clock);
      distance = 4'd1;
      value_in = 4'b0110;
      #1;
      check("lat_no_glitch_a", out, 4'b0000);
      #2;
      value_in = 4'b1010;
      #1;
      check("lat_no_glitch_b", out, 4'b0000);
      @(posedge clock);
      #1;
      check("lat_capture", out, 4'b0101);

`ifdef RSHIFT_ARITH_EN
      arith = 1'b1;
      step("ar_d1",      4'd1, 4'b1010, 4'b1101);
      step("ar_d5",      4'd5, 4'b1010, 4'b1111);
      step("ar_d2_pos",  4'd2, 4'b0110, 4'b0001);
      step("ar_d4_pos",  4'd4, 4'b0111, 4'b0000);
      arith = 1'b0;
      step("lg_d1",      4'd1, 4'b1010, 4'b0101);
      step("lg_d5",      4'd5, 4'b1010, 4'b0000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
